// File: rtl/cipher_pkg.sv
// Shared constants, FSM encoding and letter helpers for the shift cipher engine.
package cipher_pkg;

   localparam int ALPHABET_LEN = 26;

   localparam logic [7:0] ASCII_UC_A = 8'h41;
   localparam logic [7:0] ASCII_UC_Z = 8'h5A;
   localparam logic [7:0] ASCII_LC_A = 8'h61;
   localparam logic [7:0] ASCII_LC_Z = 8'h7A;

   localparam logic MODE_CAESAR  = 1'b0;
   localparam logic MODE_ROLLING = 1'b1;
   localparam logic DIR_DEC      = 1'b0;
   localparam logic DIR_ENC      = 1'b1;

   typedef enum logic {
      READY = 1'b0,
      LOAD  = 1'b1
   } state_t;

   function automatic logic is_upper(input logic [7:0] c);
      return (c >= ASCII_UC_A) && (c <= ASCII_UC_Z);
   endfunction

   function automatic logic is_lower(input logic [7:0] c);
      return (c >= ASCII_LC_A) && (c <= ASCII_LC_Z);
   endfunction

endpackage

// File: rtl/shift_alpha_unit.sv
// Combinational single-symbol shift: letters rotate within their case when
// ALPHA_WRAP=1 (key already reduced below 26), otherwise plain modular add/sub.
module shift_alpha_unit
   import cipher_pkg::*;
#(
   parameter int D_WIDTH    = 8,
   parameter int ALPHA_WRAP = 1
) (
   input  logic [D_WIDTH-1:0] sym,
   input  logic [D_WIDTH-1:0] k,
   input  logic               dir,
   output logic [D_WIDTH-1:0] res
);

   generate
      if (ALPHA_WRAP != 0) begin : g_alpha
         logic [7:0] base;
         logic [7:0] off;
         logic [8:0] t;
         logic       up;
         logic       lo;

         // Rotate within A-Z / a-z; a single correction suffices since k < 26
         always_comb begin
            up   = is_upper(sym);
            lo   = is_lower(sym);
            base = up ? ASCII_UC_A : ASCII_LC_A;
            off  = sym - base;
            if (dir == DIR_ENC) begin
               t = {1'b0, off} + {1'b0, k};
               if (t >= 9'(ALPHABET_LEN)) t = t - 9'(ALPHABET_LEN);
            end else begin
               t = {1'b0, off} - {1'b0, k};
               if (t[8]) t = t + 9'(ALPHABET_LEN);
            end
            res = sym;
            if (up || lo) res = base + t[7:0];
         end
      end else begin : g_plain
         // Natural truncation gives mod 2^D_WIDTH
         always_comb begin
            res = (dir == DIR_ENC) ? sym + k : sym - k;
         end
      end
   endgenerate

endmodule

// File: rtl/shift_cipher_engine.sv
// Streaming shift cipher: key-load FSM reducing one key symbol per cycle,
// rolling key index, and a 2-stage symbol pipeline (select key / shift result).
module shift_cipher_engine
   import cipher_pkg::*;
#(
   parameter int D_WIDTH    = 8,
   parameter int KEY_WIDTH  = 16,
   parameter int ALPHA_WRAP = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [D_WIDTH-1:0]   data_i,
   input  logic                 valid_i,
   input  logic                 sof_i,
   input  logic                 mode_i,
   input  logic                 dir_i,
   input  logic [KEY_WIDTH-1:0] key,
   input  logic                 key_load_i,
   output logic                 busy,
   output logic [D_WIDTH-1:0]   data_o,
   output logic                 valid_o
);

   localparam int KEY_SYMS = KEY_WIDTH / D_WIDTH;
   localparam int IDX_W    = (KEY_SYMS > 1) ? $clog2(KEY_SYMS) : 1;
   localparam int STAGES   = 2;

   state_t                             state, state_nxt;
   logic [IDX_W-1:0]                   ld_cnt;
   logic [IDX_W-1:0]                   idx, idx_use, idx_nxt;
   logic [KEY_SYMS-1:0][D_WIDTH-1:0]   key_q;
   logic [KEY_SYMS-1:0][D_WIDTH-1:0]   key_reg;
   logic [D_WIDTH-1:0]                 red_sym;
   logic [D_WIDTH-1:0]                 sel_key;
   logic                               accept;
   logic                               is_let;
   logic                               ld_last;

   logic [STAGES:1]                    vld_pipe;
   logic [D_WIDTH-1:0]                 s1_sym;
   logic [D_WIDTH-1:0]                 s1_key;
   logic                               s1_dir;
   logic [D_WIDTH-1:0]                 s1_res;

   function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
      return (i == IDX_W'(KEY_SYMS - 1)) ? '0 : i + 1'b1;
   endfunction

   assign ld_last = (ld_cnt == IDX_W'(KEY_SYMS - 1));
   assign accept  = valid_i && !busy;

   // ---------------- key reduction ----------------
   generate
      if (ALPHA_WRAP != 0) begin : g_red
         assign red_sym = D_WIDTH'(key_q[ld_cnt] % ALPHABET_LEN);
         assign is_let  = is_upper(data_i) || is_lower(data_i);
      end else begin : g_nored
         assign red_sym = key_q[ld_cnt];
         assign is_let  = 1'b1;
      end
   endgenerate

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst_n) state <= READY;
      else       state <= state_nxt;
   end

   // FSM next state: one LOAD cycle per key symbol, loads ignored while in LOAD
   always_comb begin
      state_nxt = state;
      case (state)
         READY:   if (key_load_i) state_nxt = LOAD;
         LOAD:    if (ld_last)    state_nxt = READY;
         default: state_nxt = READY;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy = (state == LOAD);
   end

   // Key capture and per-cycle reduction into the working key registers
   always_ff @(posedge clk) begin
      if (rst_n) begin
         key_q   <= '0;
         key_reg <= '0;
         ld_cnt  <= '0;
      end else if (state == READY) begin
         if (key_load_i) begin
            key_q  <= key;
            ld_cnt <= '0;
         end
      end else begin
         key_reg[ld_cnt] <= red_sym;
         ld_cnt          <= idx_inc(ld_cnt);
      end
   end

   // ---------------- key index ----------------
   assign idx_use = sof_i ? '0 : idx;
   assign sel_key = (mode_i == MODE_ROLLING) ? key_reg[idx_use] : key_reg[0];

   // Rolling mode advances only on letters; Caesar mode holds unless sof restarts
   always_comb begin
      idx_nxt = idx;
      if (accept) begin
         if (mode_i == MODE_ROLLING) idx_nxt = is_let ? idx_inc(idx_use) : idx_use;
         else if (sof_i)             idx_nxt = idx_inc('0);
      end
   end

   // Key index register
   always_ff @(posedge clk) begin
      if (rst_n) idx <= '0;
      else       idx <= idx_nxt;
   end

   // ---------------- pipeline ----------------
   // Valid shift register; reset flushes anything in flight
   always_ff @(posedge clk) begin
      if (rst_n) vld_pipe <= '0;
      else       vld_pipe <= {vld_pipe[STAGES-1:1], accept};
   end

   // Stage 1: symbol with the key it was accepted with
   always_ff @(posedge clk) begin
      if (rst_n) begin
         s1_sym <= '0;
         s1_key <= '0;
         s1_dir <= DIR_DEC;
      end else if (accept) begin
         s1_sym <= data_i;
         s1_key <= sel_key;
         s1_dir <= dir_i;
      end
   end

   shift_alpha_unit #(
      .D_WIDTH   (D_WIDTH),
      .ALPHA_WRAP(ALPHA_WRAP)
   ) u_shift (
      .sym(s1_sym),
      .k  (s1_key),
      .dir(s1_dir),
      .res(s1_res)
   );

   // Stage 2: result register, holds last value between symbols
   always_ff @(posedge clk) begin
      if (rst_n)            data_o <= '0;
      else if (vld_pipe[1]) data_o <= s1_res;
   end

   assign valid_o = vld_pipe[STAGES];

endmodule

// File: tb/tb_shift_cipher_engine.sv
// Directed bench: letter-wrap engine (a) and plain modular engine (b) share inputs.
module tb_shift_cipher_engine;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  data_i;
   logic        valid_i, sof_i, mode_i, dir_i, key_load_i;
   logic [15:0] key;
   logic        a_busy, a_valid, b_busy, b_valid;
   logic [7:0]  a_data, b_data;

   int n_vec = 0;
   int n_bad = 0;
   logic [7:0] qa[$];
   logic [7:0] qb[$];
   int run_b = 0, max_run_b = 0;

   always #5 clk = ~clk;

   shift_cipher_engine #(.D_WIDTH(8), .KEY_WIDTH(16), .ALPHA_WRAP(1)) u_a (
      .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i), .sof_i(sof_i),
      .mode_i(mode_i), .dir_i(dir_i), .key(key), .key_load_i(key_load_i),
      .busy(a_busy), .data_o(a_data), .valid_o(a_valid));

   shift_cipher_engine #(.D_WIDTH(8), .KEY_WIDTH(16), .ALPHA_WRAP(0)) u_b (
      .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i), .sof_i(sof_i),
      .mode_i(mode_i), .dir_i(dir_i), .key(key), .key_load_i(key_load_i),
      .busy(b_busy), .data_o(b_data), .valid_o(b_valid));

   // Output collectors
   always @(negedge clk) begin
      if (a_valid) qa.push_back(a_data);
      if (b_valid) begin
         qb.push_back(b_data);
         run_b = run_b + 1;
         if (run_b > max_run_b) max_run_b = run_b;
      end else begin
         run_b = 0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      valid_i = 1'b0;
      sof_i   = 1'b0;
      repeat (4) tick();
   endtask

   task automatic send(input logic [7:0] d, input logic dr, input logic md, input logic sf);
      data_i  = d;
      dir_i   = dr;
      mode_i  = md;
      sof_i   = sf;
      valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      sof_i   = 1'b0;
   endtask

   task automatic load_key(input logic [15:0] k);
      key        = k;
      key_load_i = 1'b1;
      tick();
      key_load_i = 1'b0;
      chk("busy_c1", {a_busy, b_busy}, 2'b11);
      tick();
      chk("busy_c2", {a_busy, b_busy}, 2'b11);
      tick();
      chk("busy_done", {a_busy, b_busy}, 2'b00);
   endtask

   task automatic clrq();
      qa.delete();
      qb.delete();
   endtask

   task automatic chkq_a(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3, input int n);
      logic [7:0] e[4];
      e = '{e0, e1, e2, e3};
      chk({tag, "_cnt"}, qa.size(), n);
      for (int i = 0; i < n && i < qa.size(); i++) chk(tag, qa[i], e[i]);
   endtask

   initial begin
      rst_n = 1'b1; data_i = '0; valid_i = 0; sof_i = 0; mode_i = 0; dir_i = 0;
      key = '0; key_load_i = 0;
      repeat (2) tick();
      chk("rst_busy",  {a_busy, b_busy}, 2'b00);
      chk("rst_valid", {a_valid, b_valid}, 2'b00);
      chk("rst_data",  {a_data, b_data}, 16'h0000);
      rst_n = 1'b0;
      tick();

      // 1: Caesar decrypt with exact latency
      load_key(16'h0003);
      clrq();
      data_i = 8'h4B; dir_i = 1'b0; mode_i = 1'b0; valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      chk("t1_lat1", a_valid, 1'b0);
      tick();
      chk("t1_lat2", a_valid, 1'b1);
      chk("t1_data", a_data, 8'h48);
      tick();
      chk("t1_lat3", a_valid, 1'b0);
      chk("t1_hold", a_data, 8'h48);
      drain();

      // 2: wrap at both ends, non-letters pass
      clrq();
      send(8'h42, 1'b0, 1'b0, 1'b0);
      send(8'h62, 1'b0, 1'b0, 1'b0);
      send(8'h5A, 1'b1, 1'b0, 1'b0);
      send(8'h20, 1'b0, 1'b0, 1'b0);
      drain();
      chkq_a("t2", 8'h59, 8'h79, 8'h43, 8'h20, 4);
      clrq();
      send(8'h37, 1'b1, 1'b0, 1'b0);
      drain();
      chkq_a("t2_digit", 8'h37, 8'h00, 8'h00, 8'h00, 1);

      // 3: rolling key, space does not advance, index wraps
      load_key(16'h0102);
      clrq();
      send(8'h43, 1'b0, 1'b1, 1'b1);
      send(8'h20, 1'b0, 1'b1, 1'b0);
      send(8'h43, 1'b0, 1'b1, 1'b0);
      send(8'h43, 1'b0, 1'b1, 1'b0);
      drain();
      chkq_a("t3", 8'h41, 8'h20, 8'h42, 8'h41, 4);

      // 4: symbol in load cycle uses old key; symbols during busy dropped; 255 mod 26
      clrq();
      key = 16'h00FF; key_load_i = 1'b1;
      data_i = 8'h41; dir_i = 1'b1; mode_i = 1'b0; valid_i = 1'b1;
      tick();
      key_load_i = 1'b0;
      chk("t4_busy1", a_busy, 1'b1);
      tick();
      chk("t4_busy2", a_busy, 1'b1);
      tick();
      valid_i = 1'b0;
      chk("t4_busy3", a_busy, 1'b0);
      drain();
      chkq_a("t4_old", 8'h43, 8'h00, 8'h00, 8'h00, 1);
      clrq();
      send(8'h41, 1'b1, 1'b0, 1'b0);
      drain();
      chkq_a("t4_red", 8'h56, 8'h00, 8'h00, 8'h00, 1);

      // 5: plain modular engine, back-to-back throughput
      load_key(16'h0007);
      clrq();
      max_run_b = 0;
      send(8'h05, 1'b0, 1'b0, 1'b0);
      send(8'h10, 1'b0, 1'b0, 1'b0);
      send(8'h00, 1'b0, 1'b0, 1'b0);
      send(8'hFF, 1'b0, 1'b0, 1'b0);
      drain();
      chk("t5_cnt", qb.size(), 4);
      if (qb.size() == 4) begin
         chk("t5_d0", qb[0], 8'hFE);
         chk("t5_d1", qb[1], 8'h09);
         chk("t5_d2", qb[2], 8'hF9);
         chk("t5_d3", qb[3], 8'hF8);
      end
      chk("t5_run", max_run_b, 4);

      // 6: reset during LOAD with a symbol in flight
      load_key(16'h0003);
      key = 16'h0505; key_load_i = 1'b1;
      data_i = 8'h4B; dir_i = 1'b0; mode_i = 1'b0; valid_i = 1'b1;
      tick();
      key_load_i = 1'b0;
      clrq();
      rst_n = 1'b1;
      tick();
      tick();
      rst_n = 1'b0;
      valid_i = 1'b0;
      chk("t6_busy", {a_busy, b_busy}, 2'b00);
      chk("t6_data", {a_data, b_data}, 16'h0000);
      drain();
      chk("t6_noval_a", qa.size(), 0);
      chk("t6_noval_b", qb.size(), 0);
      clrq();
      send(8'h4B, 1'b0, 1'b0, 1'b0);
      send(8'h4B, 1'b1, 1'b1, 1'b1);
      drain();
      chkq_a("t6_id", 8'h4B, 8'h4B, 8'h00, 8'h00, 2);
      chk("t6_id_b_cnt", qb.size(), 2);
      if (qb.size() > 0) chk("t6_id_b", qb[0], 8'h4B);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
